// File: rtl/data_wb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// copperv_pkg
//   Types and constants shared between the core and its data-side Wishbone
//   bridge.
//   - wb_bridge_state_t    : bridge FSM state encoding
//   - data_write_resp_ok   : write response value for a completed write
//   - data_write_resp_fail : write response value for err / timeout
// -----------------------------------------------------------------------------
package copperv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WRESP = 3'd3,
    RRESP = 3'd4
  } wb_bridge_state_t;

  localparam logic data_write_resp_ok   = 1'b1;
  localparam logic data_write_resp_fail = 1'b0;

endpackage

// File: rtl/data_wb_bridge_if.sv
// -----------------------------------------------------------------------------
// wishbone_if
//   Wishbone B4 classic bus bundle.
//   master drives : cyc, stb, we, adr, dat_o, sel
//   master samples: ack, err, dat_i
//   slave is the mirror image.
// -----------------------------------------------------------------------------
interface wishbone_if #(
  parameter int addr_width = 32,
  parameter int data_width = 32
);
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [addr_width-1:0]     adr;
  logic [data_width-1:0]     dat_o;
  logic [data_width/8-1:0]   sel;
  logic                      ack;
  logic                      err;
  logic [data_width-1:0]     dat_i;

  modport master (
    output cyc, stb, we, adr, dat_o, sel,
    input  ack, err, dat_i
  );

  modport slave (
    input  cyc, stb, we, adr, dat_o, sel,
    output ack, err, dat_i
  );
endinterface

// File: rtl/data_wb_bridge_watchdog.sv
// -----------------------------------------------------------------------------
// wb_watchdog
//   Counts cycles during which a bus cycle is open and flags when the slave
//   has had timeout_cycles cycles to answer.
//   clk     in  clock
//   rst     in  synchronous, active-low reset
//   clear   in  restart the count (asserted when a transaction is accepted)
//   enable  in  count this cycle (cyc high)
//   expired out high in the last allowed cycle of an open bus cycle
// -----------------------------------------------------------------------------
module wb_watchdog #(
  parameter int timeout_cycles = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(timeout_cycles + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(timeout_cycles);
  // expired is judged on the pre-increment count, so the abort edge is the
  // one that would complete the timeout_cycles-th cycle of cyc.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      // saturate instead of wrapping
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/data_wb_bridge.sv
// -----------------------------------------------------------------------------
// data_wb_bridge
//   Turns the core's data-side valid/ready write and read channels into single
//   Wishbone B4 classic transactions, one outstanding at a time, with a
//   watchdog that aborts a cycle nobody answers.
//   clk, rst                 clock, synchronous active-low reset
//   dw_data_addr_valid/ready write request (dw_addr, dw_data, dw_strobe)
//   dw_resp_valid/ready      write response (dw_resp: 1 ok, 0 fail)
//   dr_addr_valid/ready      read request (dr_addr)
//   dr_data_valid/ready      read data (dr_data, 0 on error)
//   bus_error                one-cycle pulse after err or timeout
//   wb                       Wishbone master port
// -----------------------------------------------------------------------------
module data_wb_bridge
  import copperv_pkg::*;
#(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int timeout_cycles = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dw_data_addr_valid,
  output logic                    dw_data_addr_ready,
  input  logic [addr_width-1:0]   dw_addr,
  input  logic [data_width-1:0]   dw_data,
  input  logic [data_width/8-1:0] dw_strobe,
  output logic                    dw_resp_valid,
  input  logic                    dw_resp_ready,
  output logic                    dw_resp,
  input  logic                    dr_addr_valid,
  output logic                    dr_addr_ready,
  input  logic [addr_width-1:0]   dr_addr,
  output logic                    dr_data_valid,
  input  logic                    dr_data_ready,
  output logic [data_width-1:0]   dr_data,
  output logic                    bus_error,
  wishbone_if.master              wb
);

  localparam int SEL_W = data_width / 8;

  wb_bridge_state_t        state_q, state_d;
  logic                    cyc_q, cyc_d;
  logic                    we_q, we_d;
  logic [addr_width-1:0]   adr_q, adr_d;
  logic [data_width-1:0]   dat_o_q, dat_o_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    dw_resp_valid_q, dw_resp_valid_d;
  logic                    dw_resp_q, dw_resp_d;
  logic                    dr_data_valid_q, dr_data_valid_d;
  logic [data_width-1:0]   dr_data_q, dr_data_d;
  logic                    bus_error_q, bus_error_d;
  logic                    wd_clear;
  logic                    wd_expired;
  logic                    idle;

  assign idle = (state_q == IDLE);
  // Write wins a same-cycle collision, so the read is held off that cycle.
  assign dw_data_addr_ready = idle;
  assign dr_addr_ready      = idle && !dw_data_addr_valid;

  wb_watchdog #(
    .timeout_cycles (timeout_cycles)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (cyc_q),
    .expired (wd_expired)
  );

  always_comb begin
    state_d         = state_q;
    cyc_d           = cyc_q;
    we_d            = we_q;
    adr_d           = adr_q;
    dat_o_d         = dat_o_q;
    sel_d           = sel_q;
    dw_resp_valid_d = dw_resp_valid_q;
    dw_resp_d       = dw_resp_q;
    dr_data_valid_d = dr_data_valid_q;
    dr_data_d       = dr_data_q;
    bus_error_d     = 1'b0;
    wd_clear        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dw_data_addr_valid) begin
          state_d  = WRITE;
          cyc_d    = 1'b1;
          we_d     = 1'b1;
          adr_d    = dw_addr;
          dat_o_d  = dw_data;
          sel_d    = dw_strobe;
          wd_clear = 1'b1;
        end else if (dr_addr_valid) begin
          state_d  = READ;
          cyc_d    = 1'b1;
          we_d     = 1'b0;
          adr_d    = dr_addr;
          dat_o_d  = '0;
          sel_d    = '1;
          wd_clear = 1'b1;
        end
      end

      WRITE, READ: begin
        // err outranks a simultaneous ack; a timeout behaves like err.
        if (wb.err || wb.ack || wd_expired) begin
          cyc_d = 1'b0;
          if (state_q == WRITE) begin
            state_d         = WRESP;
            dw_resp_valid_d = 1'b1;
            dw_resp_d       = (wb.err || wd_expired) ? data_write_resp_fail
                                                     : data_write_resp_ok;
          end else begin
            state_d         = RRESP;
            dr_data_valid_d = 1'b1;
            dr_data_d       = (wb.err || wd_expired) ? '0 : wb.dat_i;
          end
          bus_error_d = wb.err || wd_expired;
        end
      end

      WRESP: begin
        if (dw_resp_ready) begin
          state_d         = IDLE;
          dw_resp_valid_d = 1'b0;
        end
      end

      RRESP: begin
        if (dr_data_ready) begin
          state_d         = IDLE;
          dr_data_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      cyc_q           <= 1'b0;
      we_q            <= 1'b0;
      adr_q           <= '0;
      dat_o_q         <= '0;
      sel_q           <= '0;
      dw_resp_valid_q <= 1'b0;
      dw_resp_q       <= 1'b0;
      dr_data_valid_q <= 1'b0;
      dr_data_q       <= '0;
      bus_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cyc_q           <= cyc_d;
      we_q            <= we_d;
      adr_q           <= adr_d;
      dat_o_q         <= dat_o_d;
      sel_q           <= sel_d;
      dw_resp_valid_q <= dw_resp_valid_d;
      dw_resp_q       <= dw_resp_d;
      dr_data_valid_q <= dr_data_valid_d;
      dr_data_q       <= dr_data_d;
      bus_error_q     <= bus_error_d;
    end
  end

  assign wb.cyc        = cyc_q;
  assign wb.stb        = cyc_q;
  assign wb.we         = we_q;
  assign wb.adr        = adr_q;
  assign wb.dat_o      = dat_o_q;
  assign wb.sel        = sel_q;
  assign dw_resp_valid = dw_resp_valid_q;
  assign dw_resp       = dw_resp_q;
  assign dr_data_valid = dr_data_valid_q;
  assign dr_data       = dr_data_q;
  assign bus_error     = bus_error_q;

endmodule
